// File: rtl/timer_counter_mc_if.sv
// Register-side bundle of the multi-compare timer.
// Config, compare and write strobes in; count, match and flags out.
interface timer_counter_mc_if #(
    parameter int CNT_W   = 64,
    parameter int NUM_CMP = 4,
    parameter int DIV_W   = 8
);
    logic                     timer_en;
    logic                     div_en;
    logic [DIV_W-1:0]         div_val;
    logic                     auto_reload;
    logic                     halt_req;
    logic                     halt_ack;
    logic                     cnt_wr_lo;
    logic                     cnt_wr_hi;
    logic [31:0]              wr_data;
    logic [NUM_CMP*CNT_W-1:0] cmp_val;
    logic [NUM_CMP-1:0]       cmp_en;
    logic [NUM_CMP-1:0]       int_clr;
    logic [CNT_W-1:0]         cnt_val;
    logic [NUM_CMP-1:0]       cmp_match;
    logic [NUM_CMP-1:0]       int_st;
    logic                     ovf;

    modport master (
        output timer_en, div_en, div_val, auto_reload, halt_req,
        output cnt_wr_lo, cnt_wr_hi, wr_data,
        output cmp_val, cmp_en, int_clr,
        input  halt_ack, cnt_val, cmp_match, int_st, ovf
    );

    modport slave (
        input  timer_en, div_en, div_val, auto_reload, halt_req,
        input  cnt_wr_lo, cnt_wr_hi, wr_data,
        input  cmp_val, cmp_en, int_clr,
        output halt_ack, cnt_val, cmp_match, int_st, ovf
    );
endinterface

// File: rtl/timer_counter_mc.sv
// Multi-compare timer counter: prescaler, auto-reload, debug halt,
// split counter writes and sticky per-channel match interrupts.
module timer_counter_mc #(
    parameter int CNT_W   = 64,
    parameter int NUM_CMP = 4,
    parameter int DIV_W   = 8
) (
    input logic               clk,
    input logic               rst_n,
    timer_counter_mc_if.slave bus
);

    localparam bit HAS_HI = (CNT_W > 32);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               ovf_q, ovf_d;
    logic               delay_en_q;
    logic               halt_ack_q;
    logic [NUM_CMP-1:0] match_q;
    logic [NUM_CMP-1:0] int_st_q, int_st_d;
    logic [NUM_CMP-1:0] match;

    logic               wr_hi;
    logic               wr_any;
    logic               dis_clr;
    logic               run;
    logic               tick;
    logic               reload;
    logic [CNT_W-1:0]   wr_val;
    logic [CNT_W-1:0]   cmp0;

    assign wr_hi   = bus.cnt_wr_hi & HAS_HI;
    assign wr_any  = bus.cnt_wr_lo | wr_hi;
    assign dis_clr = ~bus.timer_en & delay_en_q;
    assign run     = bus.timer_en & ~halt_ack_q;
    assign tick    = ~bus.div_en | (div_cnt_q == bus.div_val);
    assign cmp0    = bus.cmp_val[CNT_W-1:0];
    assign reload  = bus.auto_reload & (cnt_q == cmp0);

    assign wr_val[31:0] = bus.cnt_wr_lo ? bus.wr_data
                                        : cnt_q[31:0];

    generate
        if (HAS_HI) begin : g_hi
            assign wr_val[CNT_W-1:32] =
                wr_hi ? bus.wr_data[CNT_W-33:0]
                      : cnt_q[CNT_W-1:32];
        end
    endgenerate

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_CMP; i++) begin
            match[i] = bus.cmp_en[i] &
                       (cnt_q == bus.cmp_val[i*CNT_W +: CNT_W]);
        end
    end

    // Prescaler restarts on any write or disable so a loaded value
    // gets a full tick period before it advances.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (dis_clr || wr_any || !bus.div_en) begin
            div_cnt_d = '0;
        end else if (run) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (dis_clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (wr_any) begin
            cnt_d = wr_val;
        end else if (run && tick) begin
            if (reload) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (&cnt_q) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    // Set wins over clear so a fresh match is never lost.
    assign int_st_d = (int_st_q & ~bus.int_clr) | (match & ~match_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            delay_en_q <= 1'b0;
            halt_ack_q <= 1'b0;
            match_q    <= '0;
            int_st_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            div_cnt_q  <= div_cnt_d;
            ovf_q      <= ovf_d;
            delay_en_q <= bus.timer_en;
            halt_ack_q <= bus.halt_req;
            match_q    <= match;
            int_st_q   <= int_st_d;
        end
    end

    assign bus.cnt_val   = cnt_q;
    assign bus.cmp_match = match;
    assign bus.int_st    = int_st_q;
    assign bus.ovf       = ovf_q;
    assign bus.halt_ack  = halt_ack_q;

endmodule
